reg_heap_snapshot_ctrl: RTL and testbench

- Frame-synchronous scheduler that copies the CPU register file into a packed display bus for the register-heap overlay renderer.
- Once per frame it borrows the register-file debug read port through a req/gnt handshake, reads registers 0..NUM_REGS-1 in order, and commits them atomically.
- The overlay therefore never shows a half-updated register set.
- Sits between the CPU register file's shared read port and the VGA overlay renderer.

---
 rtl/reg_heap_snapshot_ctrl.sv | 103 ++++++++++
 tb/tb_reg_heap_snapshot_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_heap_snapshot_ctrl.sv
// Once per frame, borrows the register-file debug read port, scans every register and
// commits the whole set atomically to a packed overlay bus. Define REG_HEAP_FREEZE_EN to add a freeze input.
module reg_heap_snapshot_ctrl #(
  parameter int NUM_REGS = 11,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vsync_start,
  output logic                       rf_req,
  input  logic                       rf_gnt,
  output logic [IDX_W-1:0]           rf_addr,
  input  logic [DATA_W-1:0]          rf_data,
  output logic [NUM_REGS*DATA_W-1:0] registers,
  output logic                       frame_valid,
  output logic                       busy,
  output logic                       overrun
`ifdef REG_HEAP_FREEZE_EN
  ,
  input  logic                       freeze
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, COMMIT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t                     state_reg, state_next;
  logic [IDX_W-1:0]           idx_reg, idx_next;
  logic [NUM_REGS*DATA_W-1:0] shadow_flat;
  logic                       vsync_eff;

`ifdef REG_HEAP_FREEZE_EN
  // Freeze blocks new scans and overrun reports; a scan already running still finishes.
  assign vsync_eff = vsync_start & ~freeze;
`else
  assign vsync_eff = vsync_start;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    rf_req     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (vsync_eff) begin
          idx_next   = '0;
          state_next = REQ;
        end
      end
      REQ: begin
        rf_req = 1'b1;
        if (rf_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (idx_reg == LAST_IDX) begin
          state_next = COMMIT;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = REQ;
        end
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rf_addr = idx_reg;
  assign busy    = (state_reg != IDLE);

  // Shadow words fill during the scan; the visible bus only changes at COMMIT.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_shadow
      localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(gi);
      logic [DATA_W-1:0] word_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    word_reg <= '0;
        else if (state_reg == WAIT && idx_reg == MY_IDX) word_reg <= rf_data;
      end
      assign shadow_flat[DATA_W*(NUM_REGS-gi)-1 -: DATA_W] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      registers   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      overrun   <= vsync_eff && (state_reg != IDLE);
      if (state_reg == COMMIT) begin
        registers   <= shadow_flat;
        frame_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_heap_snapshot_ctrl.sv
// Scoreboard bench for reg_heap_snapshot_ctrl: a timeline model predicts read accepts,
// commits and overrun pulses; a negedge monitor pops and compares them.
module tb_reg_heap_snapshot_ctrl;
  localparam int NR   = 11;
  localparam int DW   = 16;
  localparam int IW   = 4;
  localparam int W    = NR * DW;
  localparam int MAXT = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync_start = 1'b0;
  logic          rf_req;
  logic          rf_gnt = 1'b0;
  logic [IW-1:0] rf_addr;
  logic [DW-1:0] rf_data = '0;
  logic [W-1:0]  registers;
  logic          frame_valid, busy, overrun;
`ifdef REG_HEAP_FREEZE_EN
  logic          freeze = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_heap_snapshot_ctrl #(.NUM_REGS(NR), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .vsync_start(vsync_start),
    .rf_req(rf_req), .rf_gnt(rf_gnt), .rf_addr(rf_addr), .rf_data(rf_data),
    .registers(registers), .frame_valid(frame_valid), .busy(busy), .overrun(overrun)
`ifdef REG_HEAP_FREEZE_EN
    , .freeze(freeze)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc;
  bit mon_en = 1'b0;

  bit          vs_plan[MAXT];
  bit          gnt_plan[MAXT];
  bit          fz_plan[MAXT];
  logic [DW-1:0] base_v[NR];
  logic [DW-1:0] alt_v[NR];
  int          change_edge;

  typedef struct { int edge_n; logic [W-1:0] val; } snap_t;
  typedef struct { int edge_n; int addr; } acc_t;
  snap_t snap_q[$];
  acc_t  acc_q[$];
  int    ovr_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register-file contents as seen at a given edge.
  function automatic logic [DW-1:0] mem_val(input int k, input int t);
    return (t >= change_edge) ? alt_v[k] : base_v[k];
  endfunction

  // edge n is the n-th posedge after reset release; cyc counts posedges done
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // register-file read port: data for an accepted address appears the next cycle
  always @(posedge clk)
    if (!rst && rf_req && rf_gnt) rf_data <= mem_val(int'(rf_addr), cyc);

  // Timeline model: a frame starts on an idle-time vsync, each register needs one
  // granted request then one data cycle, the commit follows the last data cycle,
  // and any vsync seen from the first busy edge through the commit edge is an overrun.
  function automatic void build_model(input int horizon);
    int t, a, commit;
    logic [DW-1:0] vals[NR];
    logic [W-1:0] packed_v;
    t = 0;
    while (t < horizon) begin
      if (vs_plan[t] && !fz_plan[t]) begin
        a = t + 1;
        for (int k = 0; k < NR; k++) begin
          while (a < MAXT - 1 && !gnt_plan[a]) a++;
          if (a < horizon) acc_q.push_back('{a, k});
          vals[k] = mem_val(k, a);
          a += 2;
        end
        commit = a;
        packed_v = '0;
        for (int k = 0; k < NR; k++) packed_v[DW*(NR-k)-1 -: DW] = vals[k];
        if (commit < horizon) snap_q.push_back('{commit, packed_v});
        for (int u = t + 1; u <= commit; u++)
          if (u < horizon && vs_plan[u] && !fz_plan[u]) ovr_q.push_back(u);
        t = commit + 1;
      end else begin
        t++;
      end
    end
  endfunction

  // Monitor: compares every accept, commit and overrun against the scoreboard.
  logic         prev_busy = 1'b0;
  logic [W-1:0] prev_regs = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      prev_regs = '0;
    end else if (mon_en) begin
      if (rf_req) check("addr_range", W'(int'(rf_addr) < NR), W'(1));
      if (rf_req && rf_gnt) begin
        if (acc_q.size() == 0) check("accept_unexpected", W'(rf_addr), W'(0) - 1);
        else begin
          acc_t a;
          a = acc_q.pop_front();
          $display("accept  edge=%0d addr=%0d", cyc, rf_addr);
          check("accept_edge", W'(cyc), W'(a.edge_n));
          check("rf_addr", W'(rf_addr), W'(a.addr));
        end
      end
      if (prev_busy && !busy) begin
        if (snap_q.size() == 0) check("commit_unexpected", registers, ~registers);
        else begin
          snap_t s;
          s = snap_q.pop_front();
          $display("commit  edge=%0d regs=%h", cyc - 1, registers);
          check("commit_edge", W'(cyc - 1), W'(s.edge_n));
          check("snapshot", registers, s.val);
          check("frame_valid", W'(frame_valid), W'(1));
        end
      end else begin
        check("regs_stable", registers, prev_regs);
      end
      if (overrun) begin
        if (ovr_q.size() == 0) check("overrun_unexpected", W'(1), W'(0));
        else begin
          int u;
          u = ovr_q.pop_front();
          $display("overrun edge=%0d", cyc - 1);
          check("overrun_edge", W'(cyc - 1), W'(u));
        end
      end
      prev_busy = busy;
      prev_regs = registers;
    end
  end

  task automatic clear_plans();
    for (int t = 0; t < MAXT; t++) begin
      vs_plan[t] = 1'b0; gnt_plan[t] = 1'b1; fz_plan[t] = 1'b0;
    end
    change_edge = MAXT;
    for (int k = 0; k < NR; k++) begin
      base_v[k] = DW'(16'hA000 + k);
      alt_v[k]  = 16'h5555;
    end
    acc_q.delete(); snap_q.delete(); ovr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_req"}, W'(rf_req), W'(0));
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_regs"}, registers, W'(0));
    check({tag, "_frame_valid"}, W'(frame_valid), W'(0));
    check({tag, "_overrun"}, W'(overrun), W'(0));
    check({tag, "_rf_addr"}, W'(rf_addr), W'(0));
  endtask

  task automatic start_seg();
    mon_en = 1'b0;
    rst = 1'b1;
    vsync_start = 1'b0;
    rf_gnt = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #2;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  // Runs edges 0..len-1, or aborts with a reset once rst_edge edges have elapsed.
  task automatic run_seg(input int len, input int rst_edge);
    build_model((rst_edge >= 0) ? rst_edge : len);
    while (cyc < len) begin
      if (rst_edge >= 0 && cyc == rst_edge) begin
        for (int t = 0; t < MAXT; t++) vs_plan[t] = 1'b0;
        rst = 1'b1;
        vsync_start = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #2;
        rst = 1'b0;
        rst_edge = -1;
        len = 20;
      end
      vsync_start = vs_plan[cyc];
      rf_gnt      = gnt_plan[cyc];
`ifdef REG_HEAP_FREEZE_EN
      freeze      = fz_plan[cyc];
`endif
      @(posedge clk); #2;
    end
    vsync_start = 1'b0;
    @(negedge clk);
    check("pending_accepts", W'(acc_q.size()), W'(0));
    check("pending_commits", W'(snap_q.size()), W'(0));
    check("pending_overruns", W'(ovr_q.size()), W'(0));
  endtask

  initial begin
    // idle after reset
    clear_plans(); start_seg(); run_seg(100, -1);
    check("idle_regs", registers, W'(0));
    check("idle_frame_valid", W'(frame_valid), W'(0));

    // basic scan, grant always high
    clear_plans(); vs_plan[0] = 1'b1; start_seg(); run_seg(40, -1);
    check("basic_reg0", W'(registers[175:160]), W'(16'hA000));
    check("basic_reg10", W'(registers[15:0]), W'(16'hA00A));
    check("basic_frame_valid", W'(frame_valid), W'(1));

    // grant withheld for 5 cycles while reg 3 is requested
    clear_plans(); vs_plan[0] = 1'b1;
    for (int t = 7; t < 12; t++) gnt_plan[t] = 1'b0;
    start_seg(); run_seg(50, -1);

    // register file changes after reg 5 is captured
    clear_plans(); vs_plan[0] = 1'b1; change_edge = 13;
    start_seg(); run_seg(50, -1);
    check("atomic_reg5", W'(registers[DW*(NR-5)-1 -: DW]), W'(16'hA005));
    check("atomic_reg6", W'(registers[DW*(NR-6)-1 -: DW]), W'(16'h5555));

    // second vsync mid-scan and another on the commit edge
    clear_plans(); vs_plan[0] = 1'b1; vs_plan[10] = 1'b1; vs_plan[23] = 1'b1;
    start_seg(); run_seg(60, -1);

    // full scan, then a reset 9 edges into the next one
    clear_plans(); vs_plan[0] = 1'b1; vs_plan[30] = 1'b1;
    start_seg(); run_seg(100, 40);

    // randomized frames, grants and mid-scan register changes
    for (int s = 0; s < 8; s++) begin
      clear_plans();
      for (int k = 0; k < NR; k++) begin
        base_v[k] = DW'($urandom);
        alt_v[k]  = DW'($urandom);
      end
      change_edge = $urandom_range(30, 200);
      for (int t = 0; t < 240; t++) begin
        vs_plan[t]  = (t < 180) && ($urandom_range(24) == 0);
        gnt_plan[t] = ($urandom_range(2) != 0);
      end
      start_seg(); run_seg(240, -1);
    end

`ifdef REG_HEAP_FREEZE_EN
    // freeze keeps the last snapshot while further vsyncs arrive
    clear_plans(); vs_plan[0] = 1'b1; vs_plan[40] = 1'b1; vs_plan[55] = 1'b1;
    for (int t = 30; t < MAXT; t++) fz_plan[t] = 1'b1;
    change_edge = 30;
    start_seg(); run_seg(80, -1);
    check("freeze_reg0", W'(registers[175:160]), W'(16'hA000));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
